sc_stream_decoder: RTL and testbench
====================================

# sc_stream_decoder

Stochastic-to-binary decoder: counts the 1s in a unipolar stochastic bitstream over a fixed window of LEN accepted bits and presents the count as a binary result. It sits downstream of the SC datapath, at the output of the comparator/LFSR stochastic number generators and AND-gate arithmetic. It converts `output_circuit`-style bitstreams back to binary for readout or for reloading into the next generator stage. A start/valid/ready handshake frames each conversion window.

## Interface
- `LEN`, default 255: window length in accepted bits (one full 8-bit LFSR period); legal range 1..2^CW−1.
- `CW`, default 8: count width; must satisfy 2^CW−1 ≥ LEN.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  single-cycle pulse; opens a window; honoured only in IDLE.
- `clear`  in  1  synchronous abort to IDLE; discards the partial count.
- `bit_in`  in  1  stochastic bit.
- `bit_valid`  in  1  `bit_in` is sampled this cycle.
- `out_ready`  in  1  consumer accepts the result.
- `out_value`  out  CW (CW+1 with SC_BIPOLAR_EN)  decoded result.
- `out_valid`  out  1  `out_value` is valid.
- `busy`  out  1  high in COUNT.

## Operation
- States:
  - IDLE: waits for `start`. When `start` arrives, go to COUNT with `ones`=0 and `samples`=0.
  - COUNT: on each cycle with `bit_valid`=1, `samples`+=1 and `ones`+=`bit_in`. When the accepted bit is the LEN-th, latch `ones`+`bit_in` into `out_value` and go to DONE.
  - DONE: `out_valid`=1. When `out_ready`=1, go to IDLE.
- `bit_valid` gaps stall counting; cycle count is irrelevant, only accepted bits count.
- Bits presented outside COUNT are ignored.
- `start` in COUNT/DONE is ignored; it is not queued.
- `clear` has priority over everything, including `start`, completion and `out_ready`. It forces IDLE and sets `out_valid`=0. `out_value` keeps its last value.
- `ones` cannot overflow, since `ones` ≤ `samples` ≤ LEN ≤ 2^CW−1.
- LEN=1: the first accepted bit completes the window.
- `out_value` is stable from DONE entry until IDLE re-entry. It changes only at the next completion.

## Timing
- Reset values: state IDLE, `ones`=0, `samples`=0, `out_value`=0, `out_valid`=0, `busy`=0.
- `start` at cycle t gives `busy`=1 at t+1. The first bit can be accepted at t+1.
- With an unbroken `bit_valid`, the LEN-th bit accepted at cycle c gives `out_valid`=1 at c+1. This is LEN cycles after `busy` rises.
- DONE with `out_ready`=1 at cycle d gives `out_valid`=0 at d+1 (IDLE). A new `start` is accepted at d+1, so the minimum spacing between windows is LEN+2 cycles.
- `rst` asserted mid-window: immediate return to reset values. No result is produced.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `SC_BIPOLAR_EN` defined: bipolar decoding. `out_value` is CW+1 bits, signed, equal to 2·ones − LEN; range −LEN..+LEN.
- `SC_BIPOLAR_EN` not defined: unipolar. `out_value` is CW bits, unsigned, equal to `ones`.
- The conversion is applied when the result is latched, so timing is identical in both builds.

## Structure
- Shared package `sc_pkg`:
  - state enum `sc_dec_state_t` (IDLE, COUNT, DONE);
  - defaults `SC_LEN_DEFAULT`=255 and `SC_CW_DEFAULT`=8.
- The generator side also takes these constants from `sc_pkg`.
- One sub-module, `sc_ones_counter`: a `samples`/`ones` counter pair with clear, enable and a terminal flag (`samples`==LEN−1 && enable). The top level holds the FSM, the result register and the bipolar mapping.

## Test plan
- 255 consecutive valid 1s after `start` → `out_valid` one cycle after the last bit, `out_value`=255 (bipolar: +255).
- 255 valid 0s → `out_value`=0 (bipolar: −255).
- Alternating 1,0,… starting with 1, with `bit_valid` deasserted every third cycle → 128 ones counted, `out_value`=128 (bipolar: +1). Gap cycles add no count.
- Result ready with `out_ready` low for 10 cycles, plus a `start` pulse during that time → `out_value` held and `start` ignored. `out_ready`=1 → IDLE next cycle; a following `start` opens a fresh window.
- `clear` at sample 100, then `start` → the new window counts from 0. `clear`+`start` in the same cycle → remains IDLE.
- `rst` pulsed mid-window → all outputs 0 immediately. There is no `out_valid` until a new full window completes.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: decoder state
// encoding and default window/count sizing used by generators and decoders.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sc_dec_state_t;

    // One full period of an 8-bit maximal LFSR.
    localparam int SC_LEN_DEFAULT = 255;
    localparam int SC_CW_DEFAULT  = 8;

endpackage : sc_pkg

// File: rtl/sc_ones_counter.sv
// Accepted-bit / ones counter pair for one decode window, with a terminal
// flag that fires on the cycle the LEN-th bit is accepted.
module sc_ones_counter
    import sc_pkg::*;
#(
    parameter int LEN = SC_LEN_DEFAULT,
    parameter int CW  = SC_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_en,
    input  logic          i_bit,
    output logic [CW-1:0] o_ones,
    output logic          o_terminal
);

    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    logic [CW-1:0] r_samples;
    logic [CW-1:0] r_ones;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samples <= '0;
            r_ones    <= '0;
        end else if (i_clear) begin
            r_samples <= '0;
            r_ones    <= '0;
        end else if (i_en) begin
            r_samples <= r_samples + CW'(1);
            r_ones    <= r_ones + CW'(i_bit);
        end
    end

    assign o_ones     = r_ones;
    assign o_terminal = i_en && (r_samples == LAST);

endmodule : sc_ones_counter

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts 1s over LEN accepted bits and holds the
// result under a valid/ready handshake. Define SC_BIPOLAR_EN for 2*ones-LEN.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int LEN = SC_LEN_DEFAULT,
    parameter int CW  = SC_CW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 out_ready,
`ifdef SC_BIPOLAR_EN
    output logic signed [CW:0]   out_value,
`else
    output logic [CW-1:0]        out_value,
`endif
    output logic                 out_valid,
    output logic                 busy
);

`ifdef SC_BIPOLAR_EN
    localparam int OW = CW + 1;
`else
    localparam int OW = CW;
`endif

    sc_dec_state_t r_state;
    sc_dec_state_t w_state_next;

    logic [OW-1:0] r_out_value;
    logic          r_out_valid;
    logic          r_busy;

    logic          w_cnt_clear;
    logic          w_cnt_en;
    logic          w_terminal;
    logic [CW-1:0] w_ones;
    logic [CW-1:0] w_ones_final;
    logic [OW-1:0] w_result;

    // Counters sit at zero whenever no window is open, so a start always
    // begins from a clean count without an explicit load.
    assign w_cnt_clear = clear || (r_state != COUNT);
    assign w_cnt_en    = (r_state == COUNT) && bit_valid && !clear;

    sc_ones_counter #(
        .LEN (LEN),
        .CW  (CW)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cnt_clear),
        .i_en       (w_cnt_en),
        .i_bit      (bit_in),
        .o_ones     (w_ones),
        .o_terminal (w_terminal)
    );

    assign w_ones_final = w_ones + CW'(bit_in);

`ifdef SC_BIPOLAR_EN
    // Modular subtraction in CW+1 bits yields the correct two's-complement
    // value because the true result lies within -LEN..+LEN.
    assign w_result = {w_ones_final, 1'b0} - OW'(LEN);
`else
    assign w_result = w_ones_final;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)      w_state_next = COUNT;
            COUNT:   if (w_terminal) w_state_next = DONE;
            DONE:    if (out_ready)  w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
        if (clear) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_value <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next == DONE);
            r_busy      <= (w_state_next == COUNT);
            if (w_terminal) begin
                r_out_value <= w_result;
            end
        end
    end

    assign out_value = r_out_value;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule : sc_stream_decoder

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder: table of full-window patterns plus
// hand-written hold, clear, reset and LEN=1 sequences.
module tb_sc_stream_decoder;

`ifdef SC_BIPOLAR_EN
    localparam int OW  = 9;
    localparam int OW1 = 3;
`else
    localparam int OW  = 8;
    localparam int OW1 = 2;
`endif
    localparam int WIN = 255;

    logic clk = 1'b0;
    logic rst, start, clear, bit_in, bit_valid, out_ready;
    logic [OW-1:0]  out_value;
    logic           out_valid, busy;
    logic [OW1-1:0] o1_value;
    logic           o1_valid, o1_busy;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sc_stream_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_valid (out_valid),
        .busy      (busy)
    );

    sc_stream_decoder #(.LEN(1), .CW(2)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .out_ready (out_ready),
        .out_value (o1_value),
        .out_valid (o1_valid),
        .busy      (o1_busy)
    );

    typedef struct {
        string name;
        int    kind;     // 0 all ones, 1 all zeros, 2 alternating with gaps
        int    exp_uni;
        int    exp_bip;
    } vec_t;

    vec_t tbl[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [63:0] ev(input int uni, input int bip);
`ifdef SC_BIPOLAR_EN
        logic [OW-1:0] v = OW'(bip);
        return 64'(v);
`else
        logic [OW-1:0] v = OW'(uni);
        return 64'(v);
`endif
    endfunction

    function automatic logic [63:0] ev1(input int uni, input int bip);
`ifdef SC_BIPOLAR_EN
        logic [OW1-1:0] v = OW1'(bip);
        return 64'(v);
`else
        logic [OW1-1:0] v = OW1'(uni);
        return 64'(v);
`endif
    endfunction

    // Opens a window, feeds WIN accepted bits of the given pattern and checks
    // the result appears exactly one cycle after the last accepted bit.
    task automatic run_window(input string name, input int kind, input int exp_uni, input int exp_bip);
        int acc = 0;
        int k   = 0;
        logic v;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, ".busy_up"}, 64'(busy), 64'(1));
        while (acc < WIN && k < 1000) begin
            v = (kind == 2) ? (k % 3 != 2) : 1'b1;
            bit_valid = v;
            if (!v)             bit_in = 1'b1;
            else if (kind == 0) bit_in = 1'b1;
            else if (kind == 1) bit_in = 1'b0;
            else                bit_in = (acc % 2 == 0);
            if (v && acc == WIN - 1)
                check({name, ".pre_valid"}, 64'(out_valid), 64'(0));
            tick();
            if (v) acc++;
            k++;
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check({name, ".valid"}, 64'(out_valid), 64'(1));
        check({name, ".value"}, 64'(out_value), ev(exp_uni, exp_bip));
        check({name, ".busy_down"}, 64'(busy), 64'(0));
    endtask

    task automatic ack(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ".ack_valid"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        int hits;
        tbl[0] = '{name: "ones",  kind: 0, exp_uni: 255, exp_bip: 255};
        tbl[1] = '{name: "zeros", kind: 1, exp_uni: 0,   exp_bip: -255};
        tbl[2] = '{name: "alt",   kind: 2, exp_uni: 128, exp_bip: 1};

        rst = 1'b1; start = 0; clear = 0; bit_in = 0; bit_valid = 0; out_ready = 0;
        repeat (3) tick();
        check("rst.value", 64'(out_value), 64'(0));
        check("rst.valid", 64'(out_valid), 64'(0));
        check("rst.busy",  64'(busy),      64'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            run_window(tbl[i].name, tbl[i].kind, tbl[i].exp_uni, tbl[i].exp_bip);
            ack(tbl[i].name);
        end

        // Result held under back-pressure; a start during DONE is dropped.
        run_window("hold", 2, 128, 1);
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            tick();
        end
        start = 1'b0;
        check("hold.valid", 64'(out_valid), 64'(1));
        check("hold.value", 64'(out_value), ev(128, 1));
        check("hold.busy",  64'(busy),      64'(0));
        ack("hold");
        check("hold.idle_busy", 64'(busy), 64'(0));
        run_window("after_hold", 1, 0, -255);
        ack("after_hold");

        // Clear after 100 accepted bits, then a fresh window must count from 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        repeat (100) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bit_valid = 1'b0;
        check("clear.busy",  64'(busy),      64'(0));
        check("clear.valid", 64'(out_valid), 64'(0));
        check("clear.value_kept", 64'(out_value), ev(0, -255));
        run_window("post_clear", 0, 255, 255);

        // Clear in DONE drops valid but keeps the value.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_done.valid", 64'(out_valid), 64'(0));
        check("clear_done.value", 64'(out_value), ev(255, 255));

        // Clear together with start keeps the decoder idle.
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("clear_start.busy", 64'(busy), 64'(0));
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        repeat (WIN + 5) tick();
        bit_valid = 1'b0;
        check("clear_start.valid", 64'(out_valid), 64'(0));

        // Asynchronous reset mid-window.
        start = 1'b1;
        tick();
        start = 1'b0;
        bit_valid = 1'b1;
        repeat (50) tick();
        rst = 1'b1;
        #2;
        check("arst.value", 64'(out_value), 64'(0));
        check("arst.valid", 64'(out_valid), 64'(0));
        check("arst.busy",  64'(busy),      64'(0));
        tick();
        rst = 1'b0;
        hits = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (out_valid) hits++;
        end
        bit_valid = 1'b0;
        check("arst.no_valid", 64'(hits), 64'(0));
        run_window("post_rst", 0, 255, 255);
        ack("post_rst");

        // LEN=1 instance: the first accepted bit completes the window.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len1.busy", 64'(o1_busy), 64'(1));
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        bit_valid = 1'b0;
        check("len1.valid", 64'(o1_valid), 64'(1));
        check("len1.value1", 64'(o1_value), ev1(1, 1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("len1.ack", 64'(o1_valid), 64'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        tick();
        bit_valid = 1'b0;
        check("len1.value0", 64'(o1_value), ev1(0, -1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_sc_stream_decoder
